ramb_s8_port_arbiter: RTL

- Shares one 8-bit block-RAM port (512x8, 1-cycle synchronous read, EN/WE/RST style) between two requesters.
- Uses round-robin arbitration with optional bounded burst lock.
- Sits between client logic (e.g. processor data path and DMA/debug reader) and the RAM's wide port.
- Registers the RAM command, tags each read, and returns read data with a valid strobe to the originating requester.

---
 rtl/ramb_arb_pkg.sv | 22 ++
 rtl/rr_pick2.sv | 37 +++
 rtl/ramb_s8_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ramb_arb_pkg.sv
// ============================================================================
// Module  : ramb_arb_pkg
// Brief   : Shared types and constants for the ramb_s8_port_arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ramb_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  localparam int BURST_W = 4;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module  : rr_pick2
// Brief   : Two-way round-robin pick with burst retention; one-hot grant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2
  import ramb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_hold,
  output logic [1:0] grant
);

  logic w_winner;

  // Under contention the previous owner keeps the port only while it holds the lock.
  assign w_winner = lock_hold ? last : ~last;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant[REQ_ID0] = 1'b1;
      2'b10:   grant[REQ_ID1] = 1'b1;
      2'b11: begin
        if (w_winner == REQ_ID1) grant[REQ_ID1] = 1'b1;
        else                     grant[REQ_ID0] = 1'b1;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ramb_s8_port_arbiter.sv
// ============================================================================
// Module  : ramb_s8_port_arbiter
// Brief   : Two-requester arbiter for one 8-bit block-RAM port with tagged
//           read return. Define RAMB_ARB_CLEAR_EN for the power-up clear sweep.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ramb_s8_port_arbiter
  import ramb_arb_pkg::*;
#(
  parameter int                ADDR_W      = 9,
  parameter int                DATA_W      = 8,
  parameter int                MAX_BURST   = 4,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] di0,
  input  logic [DATA_W-1:0] di1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] do0,
  output logic [DATA_W-1:0] do1,
  output logic              ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_rst,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do
);

  logic               r_ready;
  logic               w_ready_next;
  logic               r_last;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [1:0]         w_pick;
  logic [1:0]         w_gnt;
  logic               w_lock_hold;
  logic               w_any;
  logic               w_win;

  logic               w_cmd_en;
  logic               w_cmd_we;
  logic [ADDR_W-1:0]  w_cmd_addr;
  logic [DATA_W-1:0]  w_cmd_di;

  logic               r_ram_en;
  logic               r_ram_we;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic [DATA_W-1:0]  r_ram_di;
  logic [1:0]         r_tag_rd;
  logic [1:0]         r_rvalid;

  // ---------------------------------------------------------------- arbitration
  assign w_lock_hold = (r_last ? (req1 & lock1) : (req0 & lock0))
                     & (r_burst_cnt < BURST_W'(MAX_BURST));

  rr_pick2 u_pick (
    .req      ({req1, req0}),
    .last     (r_last),
    .lock_hold(w_lock_hold),
    .grant    (w_pick)
  );

  assign w_gnt = r_ready ? w_pick : 2'b00;
  assign w_any = |w_gnt;
  assign w_win = w_gnt[1] ? REQ_ID1 : REQ_ID0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= REQ_ID1;
      r_burst_cnt <= '0;
    end else if (w_any) begin
      r_last <= w_win;
      if (w_win != r_last)
        r_burst_cnt <= BURST_W'(1);
      else if (r_burst_cnt != {BURST_W{1'b1}})
        r_burst_cnt <= r_burst_cnt + 1'b1;
    end else begin
      r_burst_cnt <= '0;
    end
  end

  // ------------------------------------------------------------- clear sweep
`ifdef RAMB_ARB_CLEAR_EN
  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_clr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_CLEAR)
        r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_CLEAR && r_clr_addr == {ADDR_W{1'b1}})
      w_state_next = ST_RUN;
  end

  // READY rises on the same edge that issues the final sweep write.
  assign w_ready_next = (w_state_next == ST_RUN);
`else
  logic w_unused_clear;
  assign w_unused_clear = ^CLEAR_VALUE;
  assign w_ready_next   = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready <= 1'b0;
    else        r_ready <= w_ready_next;
  end

  // --------------------------------------------------------- command stage
  always_comb begin
    w_cmd_en   = w_any;
    w_cmd_we   = w_any & (w_win ? we1 : we0);
    w_cmd_addr = w_win ? addr1 : addr0;
    w_cmd_di   = w_win ? di1 : di0;
`ifdef RAMB_ARB_CLEAR_EN
    if (r_state == ST_CLEAR) begin
      w_cmd_en   = 1'b1;
      w_cmd_we   = 1'b1;
      w_cmd_addr = r_clr_addr;
      w_cmd_di   = CLEAR_VALUE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_di   <= '0;
      r_tag_rd   <= 2'b00;
      r_rvalid   <= 2'b00;
    end else begin
      r_ram_en <= w_cmd_en;
      r_ram_we <= w_cmd_we;
      if (w_cmd_en) begin
        r_ram_addr <= w_cmd_addr;
        r_ram_di   <= w_cmd_di;
      end
      // Tag travels one stage behind the command so it lines up with RAM_DO.
      r_tag_rd <= w_gnt & ~{we1, we0};
      r_rvalid <= r_tag_rd;
    end
  end

  assign gnt0     = w_gnt[0];
  assign gnt1     = w_gnt[1];
  assign ready    = r_ready;
  assign ram_en   = r_ram_en;
  assign ram_we   = r_ram_we;
  assign ram_rst  = 1'b0;
  assign ram_addr = r_ram_addr;
  assign ram_di   = r_ram_di;
  assign rvalid0  = r_rvalid[0];
  assign rvalid1  = r_rvalid[1];
  assign do0      = ram_do;
  assign do1      = ram_do;

endmodule

`default_nettype wire
